mmio_uart_tx: RTL



---
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sitting beside dmem32 on the core data port.
// Optional interrupt output and CTRL register are enabled by defining MMIO_UART_TX_IRQ_EN.
module mmio_uart_tx #(
  parameter int unsigned SYSTEM_CLK = 100_000_000,
  parameter int unsigned BAUDRATE   = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
`ifdef MMIO_UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        tx
);

  localparam int unsigned CLKS_PER_BIT = SYSTEM_CLK / BAUDRATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             baud_done;
  logic             pop;
  logic             busy;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             full, empty;
  logic             wr_en, push_req, push;
  logic             ovf_q;
  logic [7:0]       head;

  logic unused_bits;
  assign unused_bits = ^{wmask[3:1], wdata[31:8]};

  // Bus decode
  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = hit & wmask[0];
  assign push_req = wr_en & (addr[3:0] == OFF_DATA);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign busy  = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop)
        ovf_q <= 1'b1;
      else if (wr_en && addr[3:0] == OFF_STATUS && wdata[3])
        ovf_q <= 1'b0;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata[7:0];
  end

  assign baud_done = (baud_q == BAUD_LAST);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && addr[3:0] == OFF_CTRL) irq_en_q <= wdata[0];
      irq <= irq_en_q & empty & ~busy;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (addr[3:0])
      OFF_STATUS: rdata[3:0] = {ovf_q, empty, full, busy};
`ifdef MMIO_UART_TX_IRQ_EN
      OFF_CTRL:   rdata[0]   = irq_en_q;
`endif
      default:    rdata = '0;
    endcase
  end

endmodule
